mmio_rd_dma: RTL

MMIO_RD_DMA -- requirements
Module: mmio_rd_dma

---
 rtl/mmio_rd_dma_if.sv | 24 ++
 rtl/mmio_rd_dma.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_rd_dma_if.sv
// Host memory read channel: line requests out, tagged line responses back.
// master = DMA engine side, slave = host/memory side.
interface mmio_rd_dma_if #(
    parameter int ADDR_W = 42,
    parameter int DATA_W = 512
);
    logic              c0_req_valid;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [15:0]       c0_req_mdata;
    logic              c0_almost_full;
    logic              c0_rsp_valid;
    logic [15:0]       c0_rsp_mdata;
    logic [DATA_W-1:0] c0_rsp_data;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c0_almost_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        output c0_almost_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data
    );
endinterface

// File: rtl/mmio_rd_dma.sv
// Read DMA: issues num_lines tagged cache-line reads from base_addr with a bounded
// number outstanding, and forwards each (possibly out-of-order) response with its line index.
module mmio_rd_dma #(
    parameter int ADDR_W  = 42,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [15:0]          num_lines,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    mmio_rd_dma_if.master        c0,
    output logic                 out_valid,
    output logic [15:0]          out_index,
    output logic [DATA_W-1:0]    out_data
);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [15:0]         num_q, num_d;
    logic [15:0]         idx_q, idx_d;
    logic [OUT_W-1:0]    outs_q, outs_d;
    logic [15:0]         rsp_cnt_q, rsp_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [15:0]         req_mdata_q, req_mdata_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_index_q, out_index_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic issue_s;
    logic rsp_ok_s;
    logic rsp_bad_s;
    logic start_acc_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        idx_d       = idx_q;
        outs_d      = outs_q;
        rsp_cnt_d   = rsp_cnt_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        req_mdata_d = req_mdata_q;
        out_valid_d = 1'b0;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;

        start_acc_s = start && (state_q == ST_IDLE);
        issue_s     = (state_q == ST_ISSUE) && !c0.c0_almost_full && (outs_q < MAX_OUT_C);
        // A tag with nothing outstanding cannot be a real completion, so it is flagged too.
        rsp_ok_s    = c0.c0_rsp_valid
                      && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN))
                      && (c0.c0_rsp_mdata < num_q)
                      && (outs_q != {OUT_W{1'b0}});
        rsp_bad_s   = c0.c0_rsp_valid && !rsp_ok_s;

        if (issue_s) begin
            req_valid_d = 1'b1;
            req_addr_d  = base_q + ADDR_W'(idx_q);
            req_mdata_d = idx_q;
            idx_d       = idx_q + 16'd1;
        end else begin
            req_valid_d = 1'b0;
        end

        if (rsp_ok_s) begin
            out_valid_d = 1'b1;
            out_index_d = c0.c0_rsp_mdata;
            out_data_d  = c0.c0_rsp_data;
            rsp_cnt_d   = rsp_cnt_q + 16'd1;
        end else begin
            out_valid_d = 1'b0;
        end

        case ({issue_s, rsp_ok_s})
            2'b10:   outs_d = outs_q + {{(OUT_W-1){1'b0}}, 1'b1};
            2'b01:   outs_d = outs_q - {{(OUT_W-1){1'b0}}, 1'b1};
            default: outs_d = outs_q;
        endcase

        error_d = start_acc_s ? rsp_bad_s : (error_q | rsp_bad_s);

        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    base_d    = base_addr;
                    num_d     = num_lines;
                    idx_d     = 16'd0;
                    outs_d    = {OUT_W{1'b0}};
                    rsp_cnt_d = 16'd0;
                    state_d   = (num_lines == 16'd0) ? ST_FIN : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (idx_q == (num_q - 16'd1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((outs_q == {OUT_W{1'b0}}) && (rsp_cnt_q == num_q)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // busy covers FIN itself; done lands the cycle after, when busy has dropped.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIN);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= {ADDR_W{1'b0}};
            num_q       <= 16'd0;
            idx_q       <= 16'd0;
            outs_q      <= {OUT_W{1'b0}};
            rsp_cnt_q   <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= {ADDR_W{1'b0}};
            req_mdata_q <= 16'd0;
            out_valid_q <= 1'b0;
            out_index_q <= 16'd0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            outs_q      <= outs_d;
            rsp_cnt_q   <= rsp_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_mdata_q <= req_mdata_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign c0.c0_req_valid = req_valid_q;
    assign c0.c0_req_addr  = req_addr_q;
    assign c0.c0_req_mdata = req_mdata_q;
    assign out_valid       = out_valid_q;
    assign out_index       = out_index_q;
    assign out_data        = out_data_q;
endmodule
